// File: rtl/uil_pkg.sv
// Shared types for the upper-immediate / link unit.
// Result fields are sized for the widest datapath; narrower builds use the low XLEN bits.
package uil_pkg;

  localparam int UIL_MAX_XLEN = 64;
  localparam int ILEN_STD     = 4;
  localparam int ILEN_RVC     = 2;

  typedef enum logic [1:0] {
    UIL_LUI   = 2'b00,
    UIL_AUIPC = 2'b01,
    UIL_JAL   = 2'b10,
    UIL_JALR  = 2'b11
  } uil_op_e;

  typedef struct packed {
    uil_op_e                 op;
    logic [UIL_MAX_XLEN-1:0] wdata;
    logic [UIL_MAX_XLEN-1:0] target;
    logic                    redirect;
    logic                    misalign;
  } uil_result_t;

  function automatic logic is_jump(input uil_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/uil_calc.sv
// Combinational LUI/AUIPC/JAL/JALR result computation.
// UIL_RVC_EN: honour in_rvc (2-byte link) and drop the target[1] misalign check.
module uil_calc
  import uil_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  uil_op_e          op,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic             rvc,
  output uil_result_t      res
);

  logic [XLEN-1:0] ilen;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] pc_link;
  logic [XLEN-1:0] rs1_imm;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] target;

`ifdef UIL_RVC_EN
  assign ilen = rvc ? XLEN'(ILEN_RVC) : XLEN'(ILEN_STD);
`else
  logic unused_rvc;
  assign unused_rvc = rvc;
  assign ilen       = XLEN'(ILEN_STD);
`endif

  // All sums wrap at XLEN bits by construction.
  assign pc_imm  = pc + imm;
  assign pc_link = pc + ilen;
  assign rs1_imm = rs1 + imm;

  always_comb begin
    wdata  = '0;
    target = '0;
    unique case (op)
      UIL_LUI:   wdata = imm;
      UIL_AUIPC: wdata = pc_imm;
      UIL_JAL: begin
        wdata  = pc_link;
        target = pc_imm;
      end
      UIL_JALR: begin
        wdata  = pc_link;
        target = rs1_imm & ~XLEN'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    res        = '0;
    res.op     = op;
    res.wdata  = UIL_MAX_XLEN'(wdata);
    res.target = UIL_MAX_XLEN'(target);
`ifdef UIL_RVC_EN
    res.misalign = 1'b0;
`else
    res.misalign = is_jump(op) && target[1];
`endif
    res.redirect = is_jump(op) && !res.misalign;
  end

endmodule

// File: rtl/upper_imm_link_unit.sv
// Upper-immediate / link unit: one valid/ready output stage plus a saturating redirect counter.
// Optional UIL_RVC_EN enables compressed-op link length and relaxed alignment (see uil_calc).
module upper_imm_link_unit
  import uil_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic              in_rvc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_op,
  output logic [XLEN-1:0]   out_wdata,
  output logic [XLEN-1:0]   out_target,
  output logic              out_redirect,
  output logic              out_misalign,
  output logic [CNT_W-1:0]  redirect_cnt
);

  uil_result_t      calc_res;
  uil_result_t      result_d, result_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             accept;
  logic             handoff;

  uil_calc #(.XLEN(XLEN)) u_calc (
    .op  (uil_op_e'(in_op)),
    .pc  (in_pc),
    .imm (in_imm),
    .rs1 (in_rs1),
    .rvc (in_rvc),
    .res (calc_res)
  );

  assign in_ready = rst_n && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // A flushed result is killed, never handed off.
  assign handoff  = valid_q && out_ready && !flush;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      result_d = calc_res;
    end else if (handoff) begin
      valid_d = 1'b0;
    end
    if (handoff && result_q.redirect && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_op       = result_q.op;
  assign out_wdata    = result_q.wdata[XLEN-1:0];
  assign out_target   = result_q.target[XLEN-1:0];
  assign out_redirect = result_q.redirect;
  assign out_misalign = result_q.misalign;
  assign redirect_cnt = cnt_q;

  generate
    if (XLEN < UIL_MAX_XLEN) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^{result_q.wdata[UIL_MAX_XLEN-1:XLEN],
                           result_q.target[UIL_MAX_XLEN-1:XLEN]};
    end
  endgenerate

endmodule

// File: tb/tb_upper_imm_link_unit.sv
// Randomised + directed bench for upper_imm_link_unit against a behavioural model.
// Honours UIL_RVC_EN when defined for the build.
module tb_upper_imm_link_unit;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
`ifdef UIL_RVC_EN
  localparam bit RVC_EN = 1'b1;
`else
  localparam bit RVC_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_op = 2'b00;
  logic [XLEN-1:0]   in_pc = '0;
  logic [XLEN-1:0]   in_imm = '0;
  logic [XLEN-1:0]   in_rs1 = '0;
  logic              in_rvc = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [1:0]        out_op;
  logic [XLEN-1:0]   out_wdata;
  logic [XLEN-1:0]   out_target;
  logic              out_redirect;
  logic              out_misalign;
  logic [CNT_W-1:0]  redirect_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the unit should currently hold.
  bit          m_valid = 0;
  logic [1:0]  m_op = 0;
  logic [31:0] m_wd = 0;
  logic [31:0] m_tg = 0;
  bit          m_mis = 0;
  bit          m_rd = 0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  upper_imm_link_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_pc        (in_pc),
    .in_imm       (in_imm),
    .in_rs1       (in_rs1),
    .in_rvc       (in_rvc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_wdata    (out_wdata),
    .out_target   (out_target),
    .out_redirect (out_redirect),
    .out_misalign (out_misalign),
    .redirect_cnt (redirect_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference semantics of the four ops, straight from the instruction definitions.
  function automatic void ref_calc(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] imm,
                                   input logic [31:0] rs1, input logic rvc,
                                   output logic [31:0] wd, output logic [31:0] tg,
                                   output bit mis, output bit rd);
    longint unsigned link_len;
    longint unsigned sum;
    link_len = (RVC_EN && rvc) ? 2 : 4;
    wd = 0;
    tg = 0;
    case (op)
      2'd0: wd = imm;
      2'd1: begin sum = (longint'(pc) + longint'(imm)) % (64'd1 << 32); wd = sum[31:0]; end
      2'd2: begin
        sum = (longint'(pc) + link_len) % (64'd1 << 32); wd = sum[31:0];
        sum = (longint'(pc) + longint'(imm)) % (64'd1 << 32); tg = sum[31:0];
      end
      default: begin
        sum = (longint'(pc) + link_len) % (64'd1 << 32); wd = sum[31:0];
        sum = (longint'(rs1) + longint'(imm)) % (64'd1 << 32);
        sum = sum - (sum % 2);
        tg = sum[31:0];
      end
    endcase
    mis = (op >= 2) && !RVC_EN && (((tg / 2) % 2) == 1);
    rd  = (op >= 2) && !mis;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, m_valid);
    check("redirect_cnt", redirect_cnt, m_cnt);
    if (m_valid) begin
      check("out_op", out_op, m_op);
      check("out_wdata", out_wdata, m_wd);
      check("out_target", out_target, m_tg);
      check("out_misalign", out_misalign, m_mis);
      check("out_redirect", out_redirect, m_rd);
    end
  endtask

  task automatic step(input bit rstn, input bit fl, input bit vld, input logic [1:0] op,
                      input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                      input bit rvc, input bit ordy);
    bit exp_rdy, ho, mis, rd;
    logic [31:0] wd, tg;
    @(negedge clk);
    rst_n = rstn; flush = fl; in_valid = vld; in_op = op; in_pc = pc;
    in_imm = imm; in_rs1 = rs1; in_rvc = rvc; out_ready = ordy;
    #1;
    exp_rdy = rstn && !fl && (!m_valid || ordy);
    check("in_ready", in_ready, exp_rdy);
    ho = rstn && m_valid && ordy && !fl;
    if (ho)
      $display("handoff op=%0d wdata=%h target=%h redirect=%0d misalign=%0d",
               out_op, out_wdata, out_target, out_redirect, out_misalign);
    ref_calc(op, pc, imm, rs1, rvc, wd, tg, mis, rd);
    if (!rstn) begin
      m_valid = 0; m_op = 0; m_wd = 0; m_tg = 0; m_mis = 0; m_rd = 0; m_cnt = 0;
    end else begin
      if (ho && m_rd && m_cnt < CNT_MAX) m_cnt++;
      if (fl) m_valid = 0;
      else if (vld && exp_rdy) begin
        m_valid = 1; m_op = op; m_wd = wd; m_tg = tg; m_mis = mis; m_rd = rd;
      end else if (ho) m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input bit ordy);
    step(1, 0, 0, 2'd0, 0, 0, 0, 0, ordy);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_op"}, out_op, 0);
    check({tag, "_wdata"}, out_wdata, 0);
    check({tag, "_target"}, out_target, 0);
    check({tag, "_redirect"}, out_redirect, 0);
    check({tag, "_misalign"}, out_misalign, 0);
    check({tag, "_cnt"}, redirect_cnt, 0);
  endtask

  initial begin
    int saved_cnt;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 2'd2, 32'h40, 32'h8, 0, 0, 1);
    check_all_zero("reset");

    // LUI in the very first cycle out of reset
    step(1, 0, 1, 2'd0, 32'h1000, 32'h12345000, 0, 0, 1);
    check("lui_valid", out_valid, 1);
    check("lui_wdata", out_wdata, 32'h12345000);
    check("lui_target", out_target, 0);
    check("lui_redirect", out_redirect, 0);

    step(1, 0, 1, 2'd1, 32'hFFFFF000, 32'h00002000, 0, 0, 1);
    check("auipc_wrap", out_wdata, 32'h00001000);

    step(1, 0, 1, 2'd3, 32'h100, 32'h0, 32'h203, 0, 1);
    saved_cnt = int'(redirect_cnt);
    check("jalr_target", out_target, 32'h202);
    check("jalr_wdata", out_wdata, 32'h104);
    check("jalr_misalign", out_misalign, RVC_EN ? 0 : 1);
    check("jalr_redirect", out_redirect, RVC_EN ? 1 : 0);
    idle(1);
    check("jalr_cnt", redirect_cnt, saved_cnt + (RVC_EN ? 1 : 0));

    // Stall: held JAL must stay put while out_ready is low
    step(1, 0, 1, 2'd2, 32'h2000, 32'h40, 0, 0, 0);
    saved_cnt = int'(redirect_cnt);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 0, 0);
      check("stall_wdata", out_wdata, 32'h2004);
      check("stall_target", out_target, 32'h2040);
      check("stall_cnt", redirect_cnt, saved_cnt);
    end
    idle(1);
    check("stall_handoff_cnt", redirect_cnt, saved_cnt + 1);

    // Back-to-back JALs, then a flush mid-stream
    for (int i = 0; i < 4; i++) step(1, 0, 1, 2'd2, 32'h3000 + 32'(i * 4), 32'h100, 0, 0, 1);
    step(1, 1, 1, 2'd2, 32'h4000, 32'h100, 0, 0, 1);
    check("flush_valid", out_valid, 0);
    saved_cnt = int'(redirect_cnt);
    idle(1);
    check("flush_cnt", redirect_cnt, saved_cnt);

    // Saturation of the 4-bit counter
    step(0, 0, 0, 2'd0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 0, 1, 2'd2, 32'h5000, 32'h10, 0, 0, 1);
    idle(1);
    check("sat_cnt", redirect_cnt, 4'hF);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) > 1), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 7));
    end

    // Reset in the middle of a stall
    step(1, 0, 1, 2'd2, 32'h6000, 32'h20, 0, 0, 0);
    step(1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    check_all_zero("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
